// File: rtl/symcounter_pkg.sv
// Shared types and defaults for the press-counter front end and its AnswerPeriod consumer.
// The default count width must track AnswerPeriod's userCount input width.
package symcounter_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_CNT_W           = 8;
    localparam int DEF_MAX_COUNT       = 255;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus debounce FSM; o_accept is the combinational accept strobe, o_press_pulse its registered copy.
// Latency: raw rise to o_press_pulse is DEBOUNCE_CYCLES+2 edges; no backpressure, one pulse per debounced press.
module btn_debounce
    import symcounter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_raw,
    output logic o_accept,
    output logic o_press_pulse
);

    localparam int             DW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0]  DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0]  DCNT_ONE  = DW'(1);

    logic          r_sync1;
    logic          r_btn_s;
    db_state_t     r_state;
    logic [DW-1:0] r_dcnt;
    logic          r_pulse;

    db_state_t     w_state_nxt;
    logic [DW-1:0] w_dcnt_nxt;
    logic          w_accept;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_btn_s <= 1'b0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_btn_s <= r_sync1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_dcnt  <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_pulse <= w_accept;
        end
    end

    // The counter is reused for both press and release qualification.
    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_btn_s) begin
                    w_state_nxt = PRESS_WAIT;
                    w_dcnt_nxt  = DCNT_ONE;
                end else begin
                    w_dcnt_nxt  = '0;
                end
            end
            PRESS_WAIT: begin
                if (!r_btn_s) begin
                    w_state_nxt = IDLE;
                    w_dcnt_nxt  = '0;
                end else if (r_dcnt == DCNT_LAST) begin
                    w_state_nxt = HELD;
                    w_dcnt_nxt  = '0;
                    w_accept    = 1'b1;
                end else begin
                    w_dcnt_nxt  = r_dcnt + DCNT_ONE;
                end
            end
            HELD: begin
                if (!r_btn_s) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_dcnt_nxt  = DCNT_ONE;
                end else begin
                    w_dcnt_nxt  = '0;
                end
            end
            RELEASE_WAIT: begin
                if (r_btn_s) begin
                    w_state_nxt = HELD;
                    w_dcnt_nxt  = '0;
                end else if (r_dcnt == DCNT_LAST) begin
                    w_state_nxt = IDLE;
                    w_dcnt_nxt  = '0;
                end else begin
                    w_dcnt_nxt  = r_dcnt + DCNT_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_dcnt_nxt  = '0;
            end
        endcase
    end

    assign o_accept      = w_accept;
    assign o_press_pulse = r_pulse;

endmodule

// File: rtl/user_press_counter.sv
// Debounced, saturating press counter feeding AnswerPeriod; clear beats stop beats press.
// Latency: count and pressPulse update on the same edge, DEBOUNCE_CYCLES+2 edges after a clean rise; no backpressure.
module user_press_counter
    import symcounter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int MAX_COUNT       = DEF_MAX_COUNT
) (
    input  logic             Clk100M,
    input  logic             Rst_n,
    input  logic             btnRaw,
    input  logic             clearCount,
    input  logic             stopCount,
    output logic [CNT_W-1:0] userCount,
    output logic             pressPulse,
    output logic             overflow
);

    localparam int           CW1     = CNT_W + 1;
    localparam logic [CNT_W:0] MAX_EXT = CW1'(MAX_COUNT);

    logic             w_accept;
    logic             w_pulse;
    logic [CNT_W:0]   w_count_ext;
    logic [CNT_W:0]   w_count_inc;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .i_clk         (Clk100M),
        .i_rst_n       (Rst_n),
        .i_btn_raw     (btnRaw),
        .o_accept      (w_accept),
        .o_press_pulse (w_pulse)
    );

    // Widened by one bit so the saturation compare cannot be fooled by a wrap.
    assign w_count_ext = {1'b0, r_count};
    assign w_count_inc = w_count_ext + CW1'(1);

    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clearCount) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (!stopCount && w_accept) begin
            if (w_count_ext < MAX_EXT) begin
                r_count <= w_count_inc[CNT_W-1:0];
            end else begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign userCount  = r_count;
    assign pressPulse = w_pulse;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_user_press_counter.sv
// Bench for user_press_counter: two instances (MAX_COUNT 255 and 5) share stimulus; a scoreboard checks every pulse.
module tb_user_press_counter;

    logic       Clk100M = 1'b0;
    logic       Rst_n;
    logic       btnRaw;
    logic       clearCount;
    logic       stopCount;
    logic [7:0] userCount;
    logic       pressPulse;
    logic       overflow;
    logic [7:0] sat_userCount;
    logic       sat_pressPulse;
    logic       sat_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int cnt;
        bit ovf;
        int sat_cnt;
        bit sat_ovf;
    } exp_t;

    typedef struct {
        bit stp;
        bit clr;
        int cnt;
        bit ovf;
        int sat_cnt;
        bit sat_ovf;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[16];

    always #5 Clk100M = ~Clk100M;

    user_press_counter #(.DEBOUNCE_CYCLES(4), .CNT_W(8), .MAX_COUNT(255)) dut (
        .Clk100M    (Clk100M),
        .Rst_n      (Rst_n),
        .btnRaw     (btnRaw),
        .clearCount (clearCount),
        .stopCount  (stopCount),
        .userCount  (userCount),
        .pressPulse (pressPulse),
        .overflow   (overflow)
    );

    user_press_counter #(.DEBOUNCE_CYCLES(4), .CNT_W(8), .MAX_COUNT(5)) dut_sat (
        .Clk100M    (Clk100M),
        .Rst_n      (Rst_n),
        .btnRaw     (btnRaw),
        .clearCount (clearCount),
        .stopCount  (stopCount),
        .userCount  (sat_userCount),
        .pressPulse (sat_pressPulse),
        .overflow   (sat_overflow)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every accepted press must match the oldest outstanding expectation.
    always @(negedge Clk100M) begin
        exp_t e;
        if (Rst_n && pressPulse) begin
            check("pulse_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("count_at_pulse", userCount, e.cnt);
                check("ovf_at_pulse", overflow, e.ovf);
                check("sat_count_at_pulse", sat_userCount, e.sat_cnt);
                check("sat_ovf_at_pulse", sat_overflow, e.sat_ovf);
                check("sat_pulse_coincident", sat_pressPulse, 1);
            end
        end
    end

    task automatic do_press(input bit stp, input bit clr, input exp_t e);
        @(posedge Clk100M); #2;
        stopCount = stp;
        btnRaw    = 1'b1;
        sb.push_back(e);
        repeat (5) @(posedge Clk100M);
        #2 clearCount = clr;
        @(posedge Clk100M);
        #2 clearCount = 1'b0;
        repeat (14) @(posedge Clk100M);
        #2 btnRaw = 1'b0;
        repeat (10) @(posedge Clk100M);
        #2 stopCount = 1'b0;
        check("pulse_seen", sb.size(), 0);
    endtask

    task automatic check_latency(input string name);
        for (int e = 1; e <= 7; e++) begin
            @(posedge Clk100M);
            @(negedge Clk100M);
            check(name, pressPulse, int'(e == 6));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        tbl[0]  = '{0, 0, 3, 0, 3, 0};
        tbl[1]  = '{1, 0, 3, 0, 3, 0};
        tbl[2]  = '{1, 0, 3, 0, 3, 0};
        tbl[3]  = '{0, 0, 4, 0, 4, 0};
        tbl[4]  = '{0, 0, 5, 0, 5, 0};
        tbl[5]  = '{0, 0, 6, 0, 5, 1};
        tbl[6]  = '{0, 0, 7, 0, 5, 1};
        tbl[7]  = '{0, 1, 0, 0, 0, 0};
        tbl[8]  = '{0, 0, 1, 0, 1, 0};
        tbl[9]  = '{0, 0, 2, 0, 2, 0};
        tbl[10] = '{0, 0, 3, 0, 3, 0};
        tbl[11] = '{0, 0, 4, 0, 4, 0};
        tbl[12] = '{0, 0, 5, 0, 5, 0};
        tbl[13] = '{0, 0, 6, 0, 5, 1};
        tbl[14] = '{0, 0, 7, 0, 5, 1};
        tbl[15] = '{1, 0, 7, 0, 5, 1};

        Rst_n      = 1'b0;
        btnRaw     = 1'b0;
        clearCount = 1'b0;
        stopCount  = 1'b0;
        repeat (3) @(posedge Clk100M);
        @(negedge Clk100M);
        check("rst_count", userCount, 0);
        check("rst_pulse", pressPulse, 0);
        check("rst_ovf", overflow, 0);
        check("rst_sat_count", sat_userCount, 0);
        check("rst_sat_ovf", sat_overflow, 0);
        @(posedge Clk100M); #2 Rst_n = 1'b1;
        repeat (3) @(posedge Clk100M);

        // Clean press: exact pulse timing, no pulse on release.
        #2 btnRaw = 1'b1;
        sb.push_back('{1, 0, 1, 0});
        check_latency("clean_latency");
        repeat (12) @(posedge Clk100M);
        #2 btnRaw = 1'b0;
        repeat (12) @(posedge Clk100M);
        check("clean_pulse_seen", sb.size(), 0);
        check("clean_count", userCount, 1);

        // Bounce on the rising edge, then a one-cycle glitch while held.
        #2 btnRaw = 1'b1;
        @(posedge Clk100M); #2 btnRaw = 1'b0;
        @(posedge Clk100M); #2 btnRaw = 1'b1;
        @(posedge Clk100M); #2 btnRaw = 1'b0;
        @(posedge Clk100M); #2 btnRaw = 1'b1;
        sb.push_back('{2, 0, 2, 0});
        repeat (10) @(posedge Clk100M);
        #2 btnRaw = 1'b0;
        @(posedge Clk100M); #2 btnRaw = 1'b1;
        repeat (8) @(posedge Clk100M);
        #2 btnRaw = 1'b0;
        repeat (12) @(posedge Clk100M);
        check("bounce_pulse_seen", sb.size(), 0);
        check("bounce_count", userCount, 2);

        for (int i = 0; i < 16; i++) begin
            e = '{tbl[i].cnt, tbl[i].ovf, tbl[i].sat_cnt, tbl[i].sat_ovf};
            do_press(tbl[i].stp, tbl[i].clr, e);
            check("vec_count_after", userCount, tbl[i].cnt);
            check("vec_sat_ovf_after", sat_overflow, tbl[i].sat_ovf);
        end

        // Plain clear with no press in flight.
        @(posedge Clk100M); #2 clearCount = 1'b1;
        @(posedge Clk100M); #2 clearCount = 1'b0;
        @(negedge Clk100M);
        check("clear_count", userCount, 0);
        check("clear_ovf", overflow, 0);
        check("clear_sat_count", sat_userCount, 0);
        check("clear_sat_ovf", sat_overflow, 0);

        do_press(1'b0, 1'b0, '{1, 0, 1, 0});

        // Clear lands mid-debounce; the press that completes afterwards still counts.
        @(posedge Clk100M); #2 btnRaw = 1'b1;
        sb.push_back('{1, 0, 1, 0});
        repeat (3) @(posedge Clk100M);
        #2 clearCount = 1'b1;
        @(posedge Clk100M); #2 clearCount = 1'b0;
        @(negedge Clk100M);
        check("middeb_cleared", userCount, 0);
        repeat (10) @(posedge Clk100M);
        #2 btnRaw = 1'b0;
        repeat (10) @(posedge Clk100M);
        check("middeb_pulse_seen", sb.size(), 0);
        check("middeb_count", userCount, 1);

        // Stop drops while the press is still held: that press stays uncounted.
        @(posedge Clk100M); #2;
        stopCount = 1'b1;
        btnRaw    = 1'b1;
        sb.push_back('{1, 0, 1, 0});
        repeat (8) @(posedge Clk100M);
        #2 stopCount = 1'b0;
        repeat (8) @(posedge Clk100M);
        #2 btnRaw = 1'b0;
        repeat (10) @(posedge Clk100M);
        check("stopheld_pulse_seen", sb.size(), 0);
        check("stopheld_count", userCount, 1);

        // Async reset between edges mid-PRESS_WAIT, button kept high through release.
        @(posedge Clk100M); #2 btnRaw = 1'b1;
        repeat (4) @(posedge Clk100M);
        #2 Rst_n = 1'b0;
        #1;
        check("arst_count", userCount, 0);
        check("arst_pulse", pressPulse, 0);
        check("arst_ovf", overflow, 0);
        check("arst_sat_count", sat_userCount, 0);
        repeat (2) @(posedge Clk100M);
        #2 Rst_n = 1'b1;
        sb.push_back('{1, 0, 1, 0});
        check_latency("arst_latency");
        repeat (5) @(posedge Clk100M);
        #2 btnRaw = 1'b0;
        repeat (10) @(posedge Clk100M);
        check("arst_pulse_seen", sb.size(), 0);
        check("arst_final_count", userCount, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
